// File: rtl/fp_decimator.sv
// fp_decimator: keeps one IEEE-754 sample in every DECIM valid inputs (at index
// PHASE) and buffers retained samples in a first-word-fall-through FIFO with a
// valid/ready output. The input has no backpressure: a retained sample that
// finds the FIFO full (with no pop in the same cycle) is dropped and sets the
// sticky overflow flag.
//
// Optional build macro: FP_DECIM_NAN_FLUSH_EN
//   When defined, retained NaNs are pushed as +0.0 and the sticky nan_seen
//   output is present. When undefined, payloads pass bit-exact and nan_seen
//   does not exist.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   valid_in    data_in carries a sample this cycle
//   data_in     32-bit IEEE-754 single sample
//   valid_out   FIFO head available on data_out (registered)
//   data_out    FIFO head sample (registered; holds last value when empty)
//   ready_out   consumer accepts data_out this cycle
//   overflow    sticky; a retained sample was dropped
//   fifo_level  current FIFO occupancy, 0..FIFO_DEPTH
//   nan_seen    sticky; a retained NaN was flushed (macro builds only)
module fp_decimator #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned PHASE      = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [31:0]                   data_in,
  output logic                          valid_out,
  output logic [31:0]                   data_out,
  input  logic                          ready_out,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FP_DECIM_NAN_FLUSH_EN
  ,
  output logic                          nan_seen
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] phase_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          keep_c;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          is_nan_c;
  logic [31:0]   push_data_c;
  logic [PW-1:0] wr_ptr_nxt_c;
  logic [PW-1:0] rd_ptr_nxt_c;
  logic [PW-1:0] level_nxt_c;
  logic [31:0]   head_nxt_c;

  // Keep/push/pop decisions and the next FIFO head for the registered output.
  always_comb begin
    keep_c      = valid_in && (phase_cnt == CW'(PHASE));
    full_c      = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c       = valid_out && ready_out;
    // A full FIFO still accepts a sample when a pop frees a slot this cycle.
    push_c      = keep_c && (!full_c || pop_c);
    is_nan_c    = (data_in[30:23] == 8'hFF) && (data_in[22:0] != 23'h0);
    push_data_c = data_in;
`ifdef FP_DECIM_NAN_FLUSH_EN
    if (is_nan_c) begin
      push_data_c = 32'h0000_0000;
    end
`endif
    wr_ptr_nxt_c = push_c ? (wr_ptr + PW'(1)) : wr_ptr;
    rd_ptr_nxt_c = pop_c  ? (rd_ptr + PW'(1)) : rd_ptr;
    level_nxt_c  = wr_ptr_nxt_c - rd_ptr_nxt_c;
    // Bypass when the pushed sample becomes the head: it is not in mem yet.
    if (push_c && (rd_ptr_nxt_c == wr_ptr)) begin
      head_nxt_c = push_data_c;
    end else begin
      head_nxt_c = mem[rd_ptr_nxt_c[AW-1:0]];
    end
  end

  // Sample storage; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr[AW-1:0]] <= push_data_c;
    end
  end

  // Phase counter, pointers, registered outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_out  <= 1'b0;
      data_out   <= 32'h0000_0000;
      overflow   <= 1'b0;
      fifo_level <= '0;
`ifdef FP_DECIM_NAN_FLUSH_EN
      nan_seen   <= 1'b0;
`endif
    end else begin
      if (valid_in) begin
        if (phase_cnt == CW'(DECIM - 1)) begin
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_cnt + CW'(1);
        end
      end
      wr_ptr     <= wr_ptr_nxt_c;
      rd_ptr     <= rd_ptr_nxt_c;
      fifo_level <= level_nxt_c;
      valid_out  <= (level_nxt_c != '0);
      if (level_nxt_c != '0) begin
        data_out <= head_nxt_c;
      end
      if (keep_c && !push_c) begin
        overflow <= 1'b1;
      end
`ifdef FP_DECIM_NAN_FLUSH_EN
      if (keep_c && is_nan_c) begin
        nan_seen <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/fp_decimator.md
Name: fp_decimator

Overview:
- Downstream stage of fp_lowpass_fir. Consumes the filtered IEEE-754 single-precision stream (valid_out/data_out of the LPF) and keeps one sample in every DECIM, at a fixed phase.
- Retained samples are buffered in a small FIFO and presented on a valid/ready output interface, so a stalling consumer does not block the free-running LPF.
- Input has no backpressure. Samples that arrive when the FIFO is full are dropped and flagged.

Parameters:
- DECIM, 4, decimation factor; legal range >= 1; 1 = pass-through.
- PHASE, 0, index within each group of DECIM input samples that is retained; legal range 0..DECIM-1.
- FIFO_DEPTH, 8, output buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in carries a sample this cycle (LPF valid_out).
- data_in  input  32  IEEE-754 single sample.
- valid_out  output  1  FIFO head available on data_out.
- data_out  output  32  FIFO head sample.
- ready_out  input  1  consumer accepts data_out this cycle.
- overflow  output  1  sticky; a retained sample was dropped.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- nan_seen  output  1  sticky; only present with FP_DECIM_NAN_FLUSH_EN.

Behaviour:
- Reset (rst=1 at posedge) values:
  - valid_out = 0, data_out = 32'h0, overflow = 0, fifo_level = 0, nan_seen = 0.
  - Phase counter = 0; FIFO pointers cleared.
  - Reset mid-operation flushes all buffered samples and restarts phase at 0.
- Phase counter:
  - Increments only on cycles with valid_in = 1, counting 0..DECIM-1 and wrapping DECIM-1 -> 0.
  - Idle cycles (valid_in = 0) do not advance it.
- Keep rule: a sample is retained when valid_in = 1 and the counter equals PHASE, using the pre-increment value. With DECIM=1 every valid sample is retained.
- Push and pop:
  - A retained sample is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is discarded, overflow is set to 1 and held until rst, and the FIFO contents are unchanged.
  - Pop occurs when valid_out = 1 and ready_out = 1.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Output timing:
  - First-word-fall-through; data_out and valid_out are registered.
  - A sample retained at posedge t into an empty FIFO gives valid_out = 1 with that data after posedge t, i.e. 1-cycle latency.
  - data_out holds stable while valid_out = 1 and ready_out = 0.
  - When valid_out = 0, data_out holds its last value; it is 0 after reset.
- Ordering: strict FIFO order. Samples are never reordered or duplicated.
- Arithmetic: no arithmetic on the payload. Bits pass through unmodified (-0.0, denormals and Inf are preserved), except as described under Optional Feature.
- fifo_level: 0..FIFO_DEPTH inclusive. It equals FIFO_DEPTH when full and never exceeds it.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Unretained valid samples and ready_out while empty have no effect.

Optional Feature:
- Macro: FP_DECIM_NAN_FLUSH_EN.
- Defined:
  - Any retained sample with exponent 8'hFF and mantissa != 0 (NaN) is pushed as 32'h00000000.
  - nan_seen becomes 1 and stays set until rst.
  - Inf (mantissa 0) passes unchanged.
  - Unretained NaNs are ignored and do not set nan_seen.
- Undefined:
  - NaN payloads pass bit-exact.
  - The nan_seen port does not exist.

Test Plan:
- Basic decimation: DECIM=4, PHASE=0, ready_out=1, inputs 32'h3F800000, 40000000, 40400000, 40800000, 40A00000 on consecutive cycles -> outputs exactly 3F800000 then 40A00000, each 1 cycle after its input cycle; overflow=0.
- Phase and gaps: DECIM=3, PHASE=2, valid_in pattern 1,0,1,0,0,1 with samples A,B,C -> only C is output; idle cycles do not advance the phase.
- Backpressure and overflow: DECIM=1, FIFO_DEPTH=8, ready_out=0, 10 valid samples S0..S9 -> fifo_level reaches 8 and overflow=1 after S8. Then raise ready_out -> S0..S7 drain in order, and fifo_level returns to 0.
- Full with simultaneous pop: FIFO full, ready_out=1 and a retained S in the same cycle -> S accepted, fifo_level stays 8, overflow stays 0, and S appears last.
- Mid-run reset: 3 entries buffered, assert rst for 1 cycle -> valid_out=0, fifo_level=0, overflow=0. The next valid sample is phase 0.
- NaN flush (FP_DECIM_NAN_FLUSH_EN defined), DECIM=1:
  - Input 7FC00000 -> output 00000000, nan_seen=1.
  - Input 7F800000 -> output 7F800000.
  - Without the macro, 7FC00000 passes unchanged.
